// File: rtl/cache_mem_arbiter.sv
// Arbitrates icache/dcache line traffic onto one memory port.
// One transaction in flight; ties alternate via last_grant.
module cache_mem_arbiter #(
  parameter int CACHE_LINE_SIZE = 256,
  parameter int ADDR_WIDTH      = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_read,
  input  logic [ADDR_WIDTH-1:0]      i_addr,
  output logic [CACHE_LINE_SIZE-1:0] i_rdata,
  output logic                       i_resp,
  input  logic                       d_read,
  input  logic                       d_write,
  input  logic [ADDR_WIDTH-1:0]      d_addr,
  input  logic [CACHE_LINE_SIZE-1:0] d_wdata,
  output logic [CACHE_LINE_SIZE-1:0] d_rdata,
  output logic                       d_resp,
  output logic                       mem_read,
  output logic                       mem_write,
  output logic [ADDR_WIDTH-1:0]      mem_addr,
  output logic [CACHE_LINE_SIZE-1:0] mem_wdata,
  input  logic [CACHE_LINE_SIZE-1:0] mem_rdata,
  input  logic                       mem_resp
);

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D,
    DONE
  } state_t;

  state_t state, state_d;
  logic   last_d;
  logic   i_pend, d_pend;
  logic   grant_i, grant_d;
  logic   done_i, done_d;

  always_comb begin
    state_d = state;
    grant_i = 1'b0;
    grant_d = 1'b0;
    done_i  = 1'b0;
    done_d  = 1'b0;
    i_pend  = i_read;
    d_pend  = d_read | d_write;
    unique case (state)
      IDLE: begin
        if (i_pend && d_pend) begin
          grant_i = last_d;
          grant_d = !last_d;
        end else begin
          grant_i = i_pend;
          grant_d = d_pend;
        end
        if (grant_i)
          state_d = SERVE_I;
        else if (grant_d)
          state_d = SERVE_D;
      end
      SERVE_I: begin
        if (mem_resp) begin
          done_i  = 1'b1;
          state_d = DONE;
        end
      end
      SERVE_D: begin
        if (mem_resp) begin
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // last_d resets high so the icache wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      last_d <= 1'b1;
    end else begin
      state <= state_d;
      if (grant_i)
        last_d <= 1'b0;
      else if (grant_d)
        last_d <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      i_resp    <= 1'b0;
      d_resp    <= 1'b0;
    end else begin
      i_resp <= done_i;
      d_resp <= done_d;
      if (grant_i) begin
        mem_addr  <= i_addr;
        mem_read  <= 1'b1;
        mem_write <= 1'b0;
      end else if (grant_d) begin
        mem_addr  <= d_addr;
        mem_read  <= !d_write;
        mem_write <= d_write;
        if (d_write)
          mem_wdata <= d_wdata;
      end else if (done_i || done_d) begin
        mem_read  <= 1'b0;
        mem_write <= 1'b0;
      end
      if (done_i)
        i_rdata <= mem_rdata;
      // Writebacks leave d_rdata untouched.
      if (done_d && mem_read)
        d_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter.
// Inputs change 1ns after the rising edge; outputs are sampled there.
module tb_cache_mem_arbiter;

  localparam int LW = 256;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_read;
  logic [AW-1:0] i_addr;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read;
  logic          d_write;
  logic [AW-1:0] d_addr;
  logic [LW-1:0] d_wdata;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_wdata;
  logic [LW-1:0] mem_rdata;
  logic          mem_resp;

  int vectors = 0;
  int miscompares = 0;

  logic [LW-1:0] pat_a5;
  logic [LW-1:0] pat_r1;
  logic [LW-1:0] pat_r3;
  logic [LW-1:0] pat_w;
  logic [LW-1:0] pat_w2;
  logic [LW-1:0] pat_x;

  cache_mem_arbiter #(
    .CACHE_LINE_SIZE(LW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_read(i_read),
    .i_addr(i_addr),
    .i_rdata(i_rdata),
    .i_resp(i_resp),
    .d_read(d_read),
    .d_write(d_write),
    .d_addr(d_addr),
    .d_wdata(d_wdata),
    .d_rdata(d_rdata),
    .d_resp(d_resp),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [LW-1:0] obs,
                     input logic [LW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    pat_a5 = {32{8'hA5}};
    pat_r1 = {16{16'h1111}};
    pat_r3 = {8{32'h3C3C_0F0F}};
    pat_w  = {8{32'hDEAD_BEEF}};
    pat_w2 = {8{32'h0BAD_F00D}};
    pat_x  = {4{64'hFFFF_0000_FFFF_0000}};

    rst = 1'b1;
    i_read = 0; i_addr = '0;
    d_read = 0; d_write = 0;
    d_addr = '0; d_wdata = '0;
    mem_rdata = '0; mem_resp = 0;
    tick(); tick();
    chk("rst_mem_read", LW'(mem_read), 0);
    chk("rst_mem_write", LW'(mem_write), 0);
    chk("rst_i_resp", LW'(i_resp), 0);
    chk("rst_d_resp", LW'(d_resp), 0);
    chk("rst_mem_addr", LW'(mem_addr), 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_i_rdata", i_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    rst = 1'b0;
    tick();

    // icache read, mem_resp arrives on the 4th strobe cycle
    i_read = 1; i_addr = 32'h1000;
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("i_strobe", LW'(mem_read), 1);
      chk("i_noresp", LW'({i_resp, d_resp}), 0);
      tick();
    end
    chk("i_strobe4", LW'(mem_read), 1);
    chk("i_addr", LW'(mem_addr), 32'h1000);
    chk("i_nowrite", LW'(mem_write), 0);
    mem_resp = 1; mem_rdata = pat_a5;
    tick();
    mem_resp = 0; mem_rdata = '0;
    chk("i_resp", LW'(i_resp), 1);
    chk("i_d_resp", LW'(d_resp), 0);
    chk("i_rdata", i_rdata, pat_a5);
    chk("i_strobe_off", LW'(mem_read), 0);
    i_read = 0;
    tick();
    chk("i_resp_pulse", LW'(i_resp), 0);
    chk("i_rdata_hold", i_rdata, pat_a5);
    tick();
    chk("idle_quiet", LW'({mem_read, mem_write}), 0);

    // fresh reset, then a tie: icache first, then dcache write
    rst = 1; tick(); rst = 0; tick();
    i_read = 1; i_addr = 32'h3000;
    d_write = 1; d_addr = 32'h4000; d_wdata = pat_w;
    tick();
    chk("tie1_read", LW'(mem_read), 1);
    chk("tie1_write", LW'(mem_write), 0);
    chk("tie1_addr", LW'(mem_addr), 32'h3000);
    mem_resp = 1; mem_rdata = pat_r1;
    tick();
    mem_resp = 0;
    chk("tie1_i_resp", LW'(i_resp), 1);
    chk("tie1_d_resp", LW'(d_resp), 0);
    chk("tie1_rdata", i_rdata, pat_r1);
    i_read = 0;
    tick();
    chk("done_nogrant", LW'({mem_read, mem_write}), 0);
    tick();
    chk("dw_write", LW'(mem_write), 1);
    chk("dw_read", LW'(mem_read), 0);
    chk("dw_addr", LW'(mem_addr), 32'h4000);
    chk("dw_wdata", mem_wdata, pat_w);
    mem_resp = 1; mem_rdata = pat_x;
    tick();
    mem_resp = 0;
    chk("dw_d_resp", LW'(d_resp), 1);
    chk("dw_i_resp", LW'(i_resp), 0);
    chk("dw_rdata_hold", d_rdata, 0);
    chk("dw_strobe_off", LW'(mem_write), 0);
    d_write = 0;
    tick();

    // second tie: last grant was dcache, so icache again
    i_read = 1; i_addr = 32'h5000;
    d_read = 1; d_addr = 32'h6000;
    tick();
    chk("tie2_addr", LW'(mem_addr), 32'h5000);
    chk("tie2_read", LW'(mem_read), 1);
    mem_resp = 1; mem_rdata = pat_x;
    tick();
    mem_resp = 0;
    chk("tie2_i_resp", LW'(i_resp), 1);
    i_read = 0;
    tick();
    tick();
    chk("dr_addr", LW'(mem_addr), 32'h6000);
    chk("dr_read", LW'(mem_read), 1);
    chk("dr_write", LW'(mem_write), 0);
    mem_resp = 1; mem_rdata = pat_r3;
    tick();
    mem_resp = 0;
    chk("dr_d_resp", LW'(d_resp), 1);
    chk("dr_rdata", d_rdata, pat_r3);
    d_read = 0;
    tick();

    // read and write together are a writeback
    d_read = 1; d_write = 1;
    d_addr = 32'h2040; d_wdata = pat_w2;
    tick();
    chk("rw_write", LW'(mem_write), 1);
    chk("rw_read", LW'(mem_read), 0);
    chk("rw_addr", LW'(mem_addr), 32'h2040);
    chk("rw_wdata", mem_wdata, pat_w2);
    mem_resp = 1; mem_rdata = pat_a5;
    tick();
    mem_resp = 0;
    chk("rw_d_resp", LW'(d_resp), 1);
    chk("rw_rdata_hold", d_rdata, pat_r3);
    d_read = 0; d_write = 0;
    tick();

    // stray mem_resp while idle
    mem_resp = 1; mem_rdata = pat_w;
    tick();
    mem_resp = 0;
    chk("stray_resp", LW'({i_resp, d_resp}), 0);
    chk("stray_strobe", LW'({mem_read, mem_write}), 0);
    tick();
    chk("stray_resp2", LW'({i_resp, d_resp}), 0);
    chk("stray_i_rdata", i_rdata, pat_x);

    // address change mid-transaction is ignored
    i_read = 1; i_addr = 32'h7000;
    tick();
    chk("lat_read", LW'(mem_read), 1);
    chk("lat_addr", LW'(mem_addr), 32'h7000);
    i_addr = 32'h7FC0;
    tick();
    chk("lat_addr_hold", LW'(mem_addr), 32'h7000);

    // reset mid-read aborts immediately with no response
    rst = 1;
    #1;
    chk("abort_read", LW'(mem_read), 0);
    chk("abort_resp", LW'({i_resp, d_resp}), 0);
    chk("abort_addr", LW'(mem_addr), 0);
    chk("abort_i_rdata", i_rdata, 0);
    tick();
    rst = 0;
    tick();
    chk("regrant_read", LW'(mem_read), 1);
    chk("regrant_addr", LW'(mem_addr), 32'h7FC0);
    chk("regrant_noresp", LW'({i_resp, d_resp}), 0);
    mem_resp = 1; mem_rdata = pat_r1;
    tick();
    mem_resp = 0;
    chk("regrant_i_resp", LW'(i_resp), 1);
    chk("regrant_rdata", i_rdata, pat_r1);
    i_read = 0;
    tick();
    chk("final_idle", LW'({mem_read, mem_write, i_resp, d_resp}), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
